// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
// vga_scan_gen : 640x480@60 VGA scan, 64x48 cell indices, aligned/blanked RGB
// Revision     : 1.0
// ============================================================================
module vga_scan_gen #(
    parameter int CLK_DIV   = 4,
    parameter int CELL      = 10,
    parameter int COLOR_LAT = 1,
    parameter int H_ACT     = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACT     = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] color,
    output logic [5:0]  hIndex,
    output logic [5:0]  vIndex,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic        Hsync,
    output logic        Vsync
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW    = (CELL > 1) ? $clog2(CELL) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(CELL - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACT);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACT);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [HW-1:0] h, h_nx;
    logic [VW-1:0] v, v_nx;
    logic [SW-1:0] hsub, hsub_nx, vsub, vsub_nx;
    logic [5:0]    hcell, hcell_nx, vcell, vcell_nx;
    logic          run;
    logic          act0, hs0, vs0;
    logic          h_wrap, v_wrap;

    assign pix_tick    = (div == DIV_LAST);
    assign h_wrap      = (h == H_LAST);
    assign v_wrap      = (v == V_LAST);
    // The first tick after reset enters (0,0) rather than advancing past it.
    assign frame_start = pix_tick && (!run || (h_wrap && v_wrap));
    assign hIndex      = act0 ? hcell : 6'd0;
    assign vIndex      = act0 ? vcell : 6'd0;

    always_comb begin
        h_nx     = h;
        v_nx     = v;
        hsub_nx  = hsub;
        vsub_nx  = vsub;
        hcell_nx = hcell;
        vcell_nx = vcell;
        if (run) begin
            if (h_wrap) begin
                h_nx     = '0;
                hsub_nx  = '0;
                hcell_nx = '0;
                if (v_wrap) begin
                    v_nx     = '0;
                    vsub_nx  = '0;
                    vcell_nx = '0;
                end else begin
                    v_nx = v + VW'(1);
                    if (vsub == SUB_LAST) begin
                        vsub_nx  = '0;
                        vcell_nx = vcell + 6'd1;
                    end else begin
                        vsub_nx = vsub + SW'(1);
                    end
                end
            end else begin
                h_nx = h + HW'(1);
                if (hsub == SUB_LAST) begin
                    hsub_nx  = '0;
                    hcell_nx = hcell + 6'd1;
                end else begin
                    hsub_nx = hsub + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            run   <= 1'b0;
            h     <= '0;
            v     <= '0;
            hsub  <= '0;
            vsub  <= '0;
            hcell <= '0;
            vcell <= '0;
            act0  <= 1'b0;
            hs0   <= 1'b1;
            vs0   <= 1'b1;
        end else begin
            div <= pix_tick ? '0 : div + DW'(1);
            if (pix_tick) begin
                run   <= 1'b1;
                h     <= h_nx;
                v     <= v_nx;
                hsub  <= hsub_nx;
                vsub  <= vsub_nx;
                hcell <= hcell_nx;
                vcell <= vcell_nx;
                act0  <= (h_nx < H_ACT_L) && (v_nx < V_ACT_L);
                hs0   <= !((h_nx >= HS_BEG) && (h_nx < HS_END));
                vs0   <= !((v_nx >= VS_BEG) && (v_nx < VS_END));
            end
        end
    end

    // Delay line matching the renderer's colour latency.
    logic [COLOR_LAT-1:0] act_d, hs_d, vs_d;

    generate
        if (COLOR_LAT == 1) begin : g_lat_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    act_d <= '0;
                    hs_d  <= '1;
                    vs_d  <= '1;
                end else if (pix_tick) begin
                    act_d <= act0;
                    hs_d  <= hs0;
                    vs_d  <= vs0;
                end
            end
        end else begin : g_lat_many
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    act_d <= '0;
                    hs_d  <= '1;
                    vs_d  <= '1;
                end else if (pix_tick) begin
                    act_d <= {act_d[COLOR_LAT-2:0], act0};
                    hs_d  <= {hs_d[COLOR_LAT-2:0], hs0};
                    vs_d  <= {vs_d[COLOR_LAT-2:0], vs0};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vgaRed   <= 4'd0;
            vgaGreen <= 4'd0;
            vgaBlue  <= 4'd0;
            Hsync    <= 1'b1;
            Vsync    <= 1'b1;
        end else if (pix_tick) begin
            vgaRed   <= act_d[COLOR_LAT-1] ? color[11:8] : 4'd0;
            vgaGreen <= act_d[COLOR_LAT-1] ? color[7:4]  : 4'd0;
            vgaBlue  <= act_d[COLOR_LAT-1] ? color[3:0]  : 4'd0;
            Hsync    <= hs_d[COLOR_LAT-1];
            Vsync    <= vs_d[COLOR_LAT-1];
        end
    end
endmodule
`default_nettype wire
